// File: rtl/jtkcpu_pkg.sv
// Shared constants for the KCPU memory responder: address map, ROM bank offsets,
// fetch FSM state encodings and the CPU-address to ROM-byte-address mapping.
package jtkcpu_pkg;

    localparam logic [15:0] RAM_LIMIT   = 16'h07FF;
    localparam logic [15:0] IO_BASE     = 16'h0800;
    localparam logic [15:0] IO_LIMIT    = 16'h0FFF;
    localparam logic [15:0] BROM_BASE   = 16'h1000;
    localparam logic [15:0] BROM_LIMIT  = 16'h5FFF;
    localparam logic [15:0] FROM_BASE   = 16'h6000;
    localparam logic [17:0] FROM_OFFSET = 18'h3A000;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    // Banked window keeps only 14 offset bits; the fixed window wraps at 18 bits.
    function automatic logic [17:0] rom_map(input logic [15:0] cpu_addr, input logic [3:0] bank);
        logic [15:0] off;
        logic [17:0] res;
        if (cpu_addr < FROM_BASE) begin
            off = cpu_addr - BROM_BASE;
            res = {bank, off[13:0]};
        end else begin
            off = cpu_addr - FROM_BASE;
            res = FROM_OFFSET + {2'b00, off};
        end
        return res;
    endfunction

endpackage

// File: rtl/jtkcpu_cendiv.sv
// CPU clock-enable generator: cen2 every CEN_DIV clocks, cen on every second cen2.
// A stall parks the divider on its last count so the cen2/cen alternation survives.
module jtkcpu_cendiv #(
    parameter int CEN_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stall,
    output logic cen2,
    output logic cen
);

    localparam int CW = (CEN_DIV > 1) ? $clog2(CEN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CEN_DIV - 1);

    logic [CW-1:0] cnt_r;
    logic          phase_r;

    // divider counter, phase bit and registered enables
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= {CW{1'b0}};
            phase_r <= 1'b0;
            cen2    <= 1'b0;
            cen     <= 1'b0;
        end else if (cnt_r == CNT_LAST) begin
            if (!stall) begin
                cnt_r   <= {CW{1'b0}};
                cen2    <= 1'b1;
                cen     <= phase_r;
                phase_r <= ~phase_r;
            end else begin
                cen2 <= 1'b0;
                cen  <= 1'b0;
            end
        end else begin
            cnt_r <= cnt_r + CW'(1);
            cen2  <= 1'b0;
            cen   <= 1'b0;
        end
    end

endmodule

// File: rtl/jtkcpu_memresp.sv
// KCPU memory-side responder: internal RAM, I/O window and banked/fixed external ROM
// with a one-byte fetch cache; stalls the CPU enables while a ROM fetch is pending.
module jtkcpu_memresp
    import jtkcpu_pkg::*;
#(
    parameter int CEN_DIV = 4,
    parameter int RAM_AW  = 11,
    parameter int ROM_AW  = 18
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              cen2,
    output logic              cen,
    input  logic [15:0]       addr,
    input  logic [7:0]        cpu_dout,
    input  logic              we,
    input  logic [7:0]        lines,
    output logic [7:0]        cpu_din,
    output logic              io_cs,
    output logic              io_we,
    output logic [10:0]       io_addr,
    output logic [7:0]        io_dout,
    input  logic [7:0]        io_din,
    output logic              rom_cs,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    input  logic              rom_ok
);

    logic [7:0]        ram_r [0:(1<<RAM_AW)-1];
    logic [1:0]        state_r;
    logic              rom_cs_r;
    logic [ROM_AW-1:0] rom_addr_r;
    logic [7:0]        cpu_din_r;
    logic [19:0]       tag_r;
    logic [19:0]       req_tag_r;
    logic              tag_valid_r;
    logic [7:0]        tag_data_r;
    logic [7:0]        lines_r;

    logic              ram_sel_s;
    logic              io_sel_s;
    logic              rom_sel_s;
    logic [19:0]       cur_tag_s;
    logic              hit_s;
    logic              req_s;
    logic              stall_s;

    // address decode and fetch request
    always_comb begin
        ram_sel_s = (addr <= RAM_LIMIT);
        io_sel_s  = (addr >= IO_BASE) && (addr <= IO_LIMIT);
        rom_sel_s = ((addr >= BROM_BASE) && (addr <= BROM_LIMIT)) || (addr >= FROM_BASE);
        cur_tag_s = {lines[3:0], addr};
        hit_s     = tag_valid_r && (tag_r == cur_tag_s);
        // writes into ROM space are dropped, so they must not start a fetch
        req_s     = rom_sel_s && !hit_s && !we && (state_r == ST_IDLE);
        stall_s   = req_s || (state_r != ST_IDLE);
    end

    jtkcpu_cendiv #(.CEN_DIV(CEN_DIV)) u_cendiv (
        .clk   (clk),
        .rst_n (rst_n),
        .stall (stall_s),
        .cen2  (cen2),
        .cen   (cen)
    );

    // RAM write port (contents are deliberately not reset)
    always_ff @(posedge clk) begin
        if (cen2 && we && ram_sel_s) begin
            ram_r[addr[RAM_AW-1:0]] <= cpu_dout;
        end
    end

    // ROM fetch FSM, one-byte tag cache and registered read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            rom_cs_r    <= 1'b0;
            rom_addr_r  <= {ROM_AW{1'b0}};
            cpu_din_r   <= 8'h00;
            tag_r       <= 20'h00000;
            req_tag_r   <= 20'h00000;
            tag_valid_r <= 1'b0;
            tag_data_r  <= 8'h00;
            lines_r     <= 8'h00;
        end else begin
            lines_r <= lines;
            case (state_r)
                ST_IDLE: begin
                    if (req_s) begin
                        state_r    <= ST_REQ;
                        rom_cs_r   <= 1'b1;
                        rom_addr_r <= ROM_AW'(rom_map(addr, lines[3:0]));
                        req_tag_r  <= cur_tag_s;
                    end
                end
                ST_REQ: begin
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (rom_ok) begin
                        state_r     <= ST_IDLE;
                        rom_cs_r    <= 1'b0;
                        tag_r       <= req_tag_r;
                        tag_data_r  <= rom_data;
                        tag_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    rom_cs_r <= 1'b0;
                end
            endcase
            // a bank switch overrides any fill landing on the same clock
            if (lines != lines_r) begin
                tag_valid_r <= 1'b0;
            end

            if ((state_r == ST_WAIT) && rom_ok) begin
                cpu_din_r <= rom_data;
            end else if (ram_sel_s) begin
                cpu_din_r <= ram_r[addr[RAM_AW-1:0]];
            end else if (io_sel_s) begin
                cpu_din_r <= io_din;
            end else if (rom_sel_s) begin
                if (hit_s && (state_r == ST_IDLE)) begin
                    cpu_din_r <= tag_data_r;
                end else begin
                    cpu_din_r <= cpu_din_r;
                end
            end else begin
                cpu_din_r <= 8'hFF;
            end
        end
    end

    assign cpu_din  = cpu_din_r;
    assign rom_cs   = rom_cs_r;
    assign rom_addr = rom_addr_r;
    assign io_cs    = io_sel_s;
    assign io_we    = cen2 & we & io_sel_s;
    assign io_addr  = addr[10:0];
    assign io_dout  = cpu_dout;

endmodule

// File: tb/tb_jtkcpu_memresp.sv
// Scoreboard bench for jtkcpu_memresp: expected read data and ROM addresses are queued
// when stimulus is applied and compared when the responder produces them.
module tb_jtkcpu_memresp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cen2, cen;
    logic [15:0] addr;
    logic [7:0]  cpu_dout;
    logic        we;
    logic [7:0]  lines;
    logic [7:0]  cpu_din;
    logic        io_cs, io_we;
    logic [10:0] io_addr;
    logic [7:0]  io_dout;
    logic [7:0]  io_din;
    logic        rom_cs;
    logic [17:0] rom_addr;
    logic [7:0]  rom_data;
    logic        rom_ok;

    int          total = 0;
    int          bad = 0;
    logic [7:0]  exp_q[$];
    logic [17:0] rom_q[$];
    logic        exp_cen = 1'b0;

    jtkcpu_memresp #(.CEN_DIV(4), .RAM_AW(11), .ROM_AW(18)) dut (
        .clk(clk), .rst_n(rst_n), .cen2(cen2), .cen(cen),
        .addr(addr), .cpu_dout(cpu_dout), .we(we), .lines(lines),
        .cpu_din(cpu_din), .io_cs(io_cs), .io_we(io_we), .io_addr(io_addr),
        .io_dout(io_dout), .io_din(io_din), .rom_cs(rom_cs), .rom_addr(rom_addr),
        .rom_data(rom_data), .rom_ok(rom_ok)
    );

    always #5 clk = ~clk;

    // cen must appear only with cen2, on every second cen2 starting after reset
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_cen = 1'b0;
        end else if (cen2) begin
            total++;
            if (cen !== exp_cen) begin
                bad++;
                $display("FAIL cen_phase: got %b expected %b at %0t", cen, exp_cen, $time);
            end
            exp_cen = ~exp_cen;
        end else if (cen) begin
            total++;
            bad++;
            $display("FAIL cen_alone: got cen=1 expected 0 without cen2 at %0t", $time);
        end
    end

    task automatic wait_cen2;
        int n = 0;
        @(negedge clk);
        while (!cen2 && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!cen2) begin
            total++;
            bad++;
            $display("FAIL cen2_timeout: got no cen2 expected one within 64 clk");
        end
    endtask

    task automatic rom_fetch(input logic [17:0] exp_addr, input logic [7:0] data, input int dly);
        int n = 0;
        int hi = 1;
        int c2 = 0;
        logic [17:0] ea;
        logic [7:0] ed;
        rom_q.push_back(exp_addr);
        exp_q.push_back(data);
        while (!rom_cs && n < 32) begin
            @(negedge clk);
            n++;
        end
        ea = rom_q.pop_front();
        total++;
        if (!rom_cs) begin
            bad++;
            ed = exp_q.pop_front();
            $display("FAIL rom_req_timeout: got rom_cs=0 expected request for %h", ea);
        end else begin
            if (rom_addr !== ea) begin
                bad++;
                $display("FAIL rom_addr: got %h expected %h", rom_addr, ea);
            end
            while (hi < dly) begin
                @(negedge clk);
                if (cen2) c2++;
                if (!rom_cs) break;
                hi++;
            end
            rom_data = data;
            rom_ok = 1'b1;
            @(negedge clk);
            rom_ok = 1'b0;
            rom_data = 8'h00;
            ed = exp_q.pop_front();
            total++;
            if (hi != dly || c2 != 0 || rom_cs !== 1'b0) begin
                bad++;
                $display("FAIL rom_stall: got cs_len=%0d cen2s=%0d cs_after=%b expected %0d 0 0",
                         hi, c2, rom_cs, dly);
            end
            total++;
            if (cpu_din !== ed) begin
                bad++;
                $display("FAIL rom_data: got %h expected %h", cpu_din, ed);
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; addr = 16'h0800; cpu_dout = 8'h00; we = 1'b0; lines = 8'h00;
        io_din = 8'h00; rom_data = 8'h00; rom_ok = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({cen2, cen, io_we, rom_cs} !== 4'b0000 || cpu_din !== 8'h00 || rom_addr !== 18'h0) begin
            bad++;
            $display("FAIL reset_state: got cen2=%b cen=%b io_we=%b rom_cs=%b din=%h rom_addr=%h expected all 0",
                     cen2, cen, io_we, rom_cs, cpu_din, rom_addr);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_cendiv;
        int n;
        wait_cen2();
        for (int k = 0; k < 4; k++) begin
            n = 0;
            @(negedge clk);
            n++;
            while (!cen2 && n < 16) begin
                @(negedge clk);
                n++;
            end
            total++;
            if (n != 4) begin
                bad++;
                $display("FAIL cen2_period: got %0d expected 4", n);
            end
        end
    endtask

    task automatic test_ram;
        logic [15:0] wa [6] = '{16'h0123, 16'h0000, 16'h07FF, 16'h0010, 16'h0200, 16'h0201};
        logic [7:0]  wd [6] = '{8'h5A, 8'h11, 8'hEE, 8'h10, 8'hAB, 8'hCD};
        logic [7:0]  ed;
        wait_cen2();
        addr = 16'h0123; cpu_dout = 8'h5A; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
        exp_q.push_back(8'h5A);
        @(negedge clk);
        ed = exp_q.pop_front();
        total++;
        if (cpu_din !== ed || cen2 !== 1'b0) begin
            bad++;
            $display("FAIL ram_readback: got %h cen2=%b expected %h before next cen2", cpu_din, cen2, ed);
        end
        for (int i = 1; i < 4; i++) begin
            wait_cen2();
            addr = wa[i]; cpu_dout = wd[i]; we = 1'b1;
            @(negedge clk);
            we = 1'b0;
        end
        // 16-bit store: we held across two consecutive cen2
        wait_cen2();
        addr = wa[4]; cpu_dout = wd[4]; we = 1'b1;
        wait_cen2();
        addr = wa[5]; cpu_dout = wd[5];
        @(negedge clk);
        we = 1'b0;
        for (int i = 0; i < 6; i++) begin
            addr = wa[i];
            exp_q.push_back(wd[i]);
            @(negedge clk);
            ed = exp_q.pop_front();
            total++;
            if (cpu_din !== ed) begin
                bad++;
                $display("FAIL ram_read %h: got %h expected %h", wa[i], cpu_din, ed);
            end
        end
    endtask

    task automatic test_io;
        int hi = 0;
        logic [7:0] ed;
        wait_cen2();
        addr = 16'h0810; cpu_dout = 8'h77; we = 1'b1;
        #1;
        total++;
        if (io_cs !== 1'b1 || io_addr !== 11'h010 || io_we !== 1'b1 || io_dout !== 8'h77) begin
            bad++;
            $display("FAIL io_write: got cs=%b addr=%h we=%b dout=%h expected 1 010 1 77",
                     io_cs, io_addr, io_we, io_dout);
        end
        @(negedge clk);
        total++;
        if (io_we !== 1'b0) begin
            bad++;
            $display("FAIL io_we_width: got %b expected 0 one clk later", io_we);
        end
        we = 1'b0;
        addr = 16'h0FFF;
        #1;
        total++;
        if (io_cs !== 1'b1) begin
            bad++;
            $display("FAIL io_cs_top: got %b expected 1", io_cs);
        end
        addr = 16'h07FF;
        #1;
        total++;
        if (io_cs !== 1'b0) begin
            bad++;
            $display("FAIL io_cs_ram: got %b expected 0", io_cs);
        end
        @(negedge clk);
        addr = 16'h0900; io_din = 8'h3C;
        exp_q.push_back(8'h3C);
        @(negedge clk);
        ed = exp_q.pop_front();
        total++;
        if (cpu_din !== ed) begin
            bad++;
            $display("FAIL io_read: got %h expected %h", cpu_din, ed);
        end
        // a ROM-space write must neither fetch nor touch RAM
        wait_cen2();
        addr = 16'h7000; cpu_dout = 8'h99; we = 1'b1;
        @(negedge clk);
        if (rom_cs) hi++;
        addr = 16'h0000; we = 1'b0;
        exp_q.push_back(8'h11);
        @(negedge clk);
        if (rom_cs) hi++;
        ed = exp_q.pop_front();
        total++;
        if (cpu_din !== ed) begin
            bad++;
            $display("FAIL rom_write_ram: got %h expected %h", cpu_din, ed);
        end
        addr = 16'h0010;
        exp_q.push_back(8'h10);
        @(negedge clk);
        if (rom_cs) hi++;
        ed = exp_q.pop_front();
        total++;
        if (cpu_din !== ed) begin
            bad++;
            $display("FAIL io_write_ram: got %h expected %h", cpu_din, ed);
        end
        total++;
        if (hi != 0) begin
            bad++;
            $display("FAIL rom_write_cs: got %0d rom_cs clk expected 0", hi);
        end
    endtask

    task automatic test_rom_fixed;
        int hi = 0;
        logic [7:0] ed;
        wait_cen2();
        addr = 16'h6000;
        rom_fetch(18'h3A000, 8'hC3, 7);
        wait_cen2();
        addr = 16'h0123;
        wait_cen2();
        addr = 16'h6000;
        exp_q.push_back(8'hC3);
        @(negedge clk);
        ed = exp_q.pop_front();
        total++;
        if (cpu_din !== ed) begin
            bad++;
            $display("FAIL rom_hit_data: got %h expected %h", cpu_din, ed);
        end
        for (int i = 0; i < 6; i++) begin
            if (rom_cs) hi++;
            @(negedge clk);
        end
        total++;
        if (hi != 0) begin
            bad++;
            $display("FAIL rom_hit_cs: got %0d rom_cs clk expected 0", hi);
        end
        wait_cen2();
        addr = 16'hFFFF;
        rom_fetch(18'h03FFF, 8'h81, 3);
    endtask

    task automatic test_rom_bank;
        wait_cen2();
        lines = 8'h05; addr = 16'h1004;
        rom_fetch(18'h14004, 8'h42, 2);
        wait_cen2();
        lines = 8'h06;
        rom_fetch(18'h18004, 8'h24, 4);
        wait_cen2();
        lines = 8'h0F; addr = 16'h5FFF;
        rom_fetch(18'h3CFFF, 8'h5F, 2);
    endtask

    task automatic test_reset_mid;
        int n = 0;
        wait_cen2();
        lines = 8'h00; addr = 16'h6000;
        while (!rom_cs && n < 32) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (rom_cs !== 1'b0 || cpu_din !== 8'h00) begin
            bad++;
            $display("FAIL reset_mid: got rom_cs=%b din=%h expected 0 00", rom_cs, cpu_din);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rom_fetch(18'h3A000, 8'hC3, 2);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_cendiv();
        test_ram();
        test_io();
        test_rom_fixed();
        test_rom_bank();
        test_reset_mid();
        repeat (10) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
